sseg_scan_mux_2d: RTL and testbench
===================================

Name: sseg_scan_mux_2d

Overview:
- Downstream of the 00–99 counter / BIN_BCD / sseg chain.
- Time-multiplexes the two decoded digits (ones, tens) onto one shared 7-segment bus with two digit enables, as the board wiring requires.
- Adds a dead-time between digits to prevent ghosting, optional tens leading-zero blanking, a display enable, and a frame-complete strobe.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (gap + on-time); constraint SCAN_DIV >= BLANK_CYC+2.
- BLANK_CYC, 16, dead-time cycles at the start of each slot, all digits off; constraint >= 1.
- ACTIVE_LOW, 1, 1 = seg and an outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  display enable; 0 blanks the display and restarts the scan
- onesseg  in  7  ones digit segments {g..a}, 1 = lit
- tensseg  in  7  tens digit segments {g..a}, 1 = lit
- ten_bcd  in  4  tens BCD value, used only for leading-zero detection
- blank_lz  in  1  1 = suppress tens digit when ten_bcd == 0
- seg  out  7  shared segment bus, polarity per ACTIVE_LOW
- an  out  2  digit enables, an[0] = ones, an[1] = tens, polarity per ACTIVE_LOW
- digit_sel  out  1  0 = ones slot, 1 = tens slot (raw, unaffected by blanking)
- frame_tick  out  1  one-cycle pulse per completed ones+tens scan

Behaviour:
- Clock domain: single clk. rst is async assert; the first active edge after rst falls begins scanning.
- Reset values:
  - state = GAP0, slot counter = 0, holding register = 0
  - seg = all segments off; an = both off (ACTIVE_LOW=1 gives seg=7'h7F, an=2'b11)
  - digit_sel = 0, frame_tick = 0
- Slot counter width is clog2(SCAN_DIV). It counts 0..SCAN_DIV-1 within a slot.
- FSM states and durations:
  - GAP0: ones slot, dead-time, BLANK_CYC cycles.
  - ONES_ON: ones slot, on-time, SCAN_DIV-BLANK_CYC cycles.
  - GAP1: tens slot, dead-time, BLANK_CYC cycles.
  - TENS_ON: tens slot, on-time, SCAN_DIV-BLANK_CYC cycles.
  - Transitions: GAP0 -> ONES_ON when cnt == BLANK_CYC-1; ONES_ON -> GAP1 when cnt == SCAN_DIV-1 (cnt clears); GAP1 -> TENS_ON when cnt == BLANK_CYC-1; TENS_ON -> GAP0 when cnt == SCAN_DIV-1 (cnt clears).
- Full frame = 2*SCAN_DIV cycles.
- Input capture:
  - On the GAP0 -> ONES_ON edge, onesseg is captured into the holding register.
  - On the GAP1 -> TENS_ON edge, tensseg is captured, along with the lz flag (blank_lz && ten_bcd == 0).
  - Input changes during an on-phase never alter seg mid-phase.
- Outputs are registered and decoded from next-state, so they align with the state shown.
- In GAP0/GAP1: an and seg are both off.
- In ONES_ON:
  - an[0] is on.
  - seg = held ones pattern.
- In TENS_ON:
  - If lz is set, an[1] and seg are off.
  - Otherwise an[1] is on and seg = held tens pattern.
- Never more than one an bit is active in any cycle.
- Polarity: with ACTIVE_LOW=1, seg = ~pattern and on = 0. With ACTIVE_LOW=0, seg = pattern and on = 1.
- digit_sel: 0 in GAP0/ONES_ON, 1 in GAP1/TENS_ON.
- frame_tick:
  - High for exactly the first cycle of GAP0 entered from TENS_ON.
  - Not asserted after reset.
  - Not asserted on an en-forced return to GAP0.
- en = 0:
  - On the next edge, state goes to GAP0, cnt = 0, outputs off, frame_tick = 0.
  - Held there while en = 0.
  - When en = 1 resumes, a full BLANK_CYC gap precedes ONES_ON.
- en is synchronous and has lower priority than rst.
- rst mid-operation: outputs go to their off values immediately (async) regardless of state.

Test Plan:
- SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1, en=1, onesseg=7'h06, tensseg=7'h5B, blank_lz=0, release rst -> an=11 for 2 cycles; an=10 with seg=7'h79 for 6 cycles; an=11 for 2 cycles; an=01 with seg=7'h24 for 6 cycles; frame_tick=1 at cycle 16 only; period 16.
- Same setup, ten_bcd=0, blank_lz=1 -> an stays 11 and seg=7'h7F throughout TENS_ON. ones slot unchanged. digit_sel still toggles. frame_tick still pulses.
- Change onesseg from 7'h06 to 7'h3F mid ONES_ON -> seg holds 7'h79 until the next ONES_ON, which then shows 7'h40.
- Drop en to 0 during TENS_ON cycle 3 -> next edge an=11, seg=7'h7F, no frame_tick. Raise en -> 2 gap cycles, then ONES_ON.
- Assert rst asynchronously mid ONES_ON (between edges) -> an=11, seg=7'h7F, digit_sel=0 immediately. After release, timing matches scenario 1.
- ACTIVE_LOW=0, onesseg=7'h06 -> during ONES_ON seg=7'h06, an=01. During gaps an=00, seg=7'h00. Check for all cycles that an is never 11.

Source files
------------

// File: rtl/sseg_scan_mux_2d.sv
// Two-digit 7-segment scan multiplexer: ones/tens share one segment bus, with a
// dead-time gap before each digit, optional tens leading-zero blanking and a frame strobe.
module sseg_scan_mux_2d #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] onesseg,
    input  logic [6:0] tensseg,
    input  logic [3:0] ten_bcd,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       digit_sel,
    output logic       frame_tick
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [6:0]      SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]      AN_OFF   = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        GAP0    = 2'd0,
        ONES_ON = 2'd1,
        GAP1    = 2'd2,
        TENS_ON = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       hold_q, hold_d;
    logic             lz_q, lz_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             digit_sel_q, digit_sel_d;
    logic             frame_tick_q, frame_tick_d;

    function automatic logic [6:0] seg_drive(input logic [6:0] pat);
        return (ACTIVE_LOW != 0) ? ~pat : pat;
    endfunction

    function automatic logic [1:0] an_drive(input logic [1:0] on_mask);
        return (ACTIVE_LOW != 0) ? ~on_mask : on_mask;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        lz_d         = lz_q;
        frame_tick_d = 1'b0;

        if (!en) begin
            state_d = GAP0;
            cnt_d   = '0;
        end else begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            case (state_q)
                GAP0: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ONES_ON;
                        hold_d  = onesseg;
                    end
                end
                ONES_ON: begin
                    if (cnt_q == CNT_LAST) state_d = GAP1;
                end
                GAP1: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = TENS_ON;
                        hold_d  = tensseg;
                        lz_d    = blank_lz && (ten_bcd == 4'd0);
                    end
                end
                TENS_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d      = GAP0;
                        frame_tick_d = 1'b1;
                    end
                end
                default: state_d = GAP0;
            endcase
        end

        // Outputs decode the next state so the registered pins line up with state_q.
        seg_d       = SEG_OFF;
        an_d        = AN_OFF;
        digit_sel_d = (state_d == GAP1) || (state_d == TENS_ON);
        case (state_d)
            ONES_ON: begin
                seg_d = seg_drive(hold_d);
                an_d  = an_drive(2'b01);
            end
            TENS_ON: begin
                if (!lz_d) begin
                    seg_d = seg_drive(hold_d);
                    an_d  = an_drive(2'b10);
                end
            end
            default: begin
                seg_d = SEG_OFF;
                an_d  = AN_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= GAP0;
            cnt_q        <= '0;
            hold_q       <= '0;
            lz_q         <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            digit_sel_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            lz_q         <= lz_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_mux_2d.sv
// Directed bench for sseg_scan_mux_2d: an active-low and an active-high instance
// share stimulus; SCAN_DIV=8, BLANK_CYC=2 gives a 16-cycle frame.
module tb_sseg_scan_mux_2d;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] onesseg;
    logic [6:0] tensseg;
    logic [3:0] ten_bcd;
    logic       blank_lz;

    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;
    logic       ds_a, ds_b;
    logic       ft_a, ft_b;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;
    int bad_an_a = 0;
    int bad_an_b = 0;

    sseg_scan_mux_2d #(.SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .en(en), .onesseg(onesseg), .tensseg(tensseg),
        .ten_bcd(ten_bcd), .blank_lz(blank_lz), .seg(seg_a), .an(an_a),
        .digit_sel(ds_a), .frame_tick(ft_a)
    );

    sseg_scan_mux_2d #(.SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .onesseg(onesseg), .tensseg(tensseg),
        .ten_bcd(ten_bcd), .blank_lz(blank_lz), .seg(seg_b), .an(an_b),
        .digit_sel(ds_b), .frame_tick(ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit enables must never have both digits on at once.
    always @(negedge clk) begin
        if (an_a === 2'b00) bad_an_a++;
        if (an_b === 2'b11) bad_an_b++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ph=%0d observed=%h expected=%h", tag, ph, obs, exp);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_an"}, {6'd0, an_a}, 8'h03);
        chk({tag, "_seg"}, {1'b0, seg_a}, 8'h7F);
        chk({tag, "_dsel"}, {7'd0, ds_a}, 8'h00);
        chk({tag, "_ftick"}, {7'd0, ft_a}, 8'h00);
        chk({tag, "_an_hi"}, {6'd0, an_b}, 8'h00);
        chk({tag, "_seg_hi"}, {1'b0, seg_b}, 8'h00);
        chk({tag, "_ftick_hi"}, {7'd0, ft_b}, 8'h00);
    endtask

    // Frame model: phase 0-1 GAP0, 2-7 ONES_ON, 8-9 GAP1, 10-15 TENS_ON.
    task automatic run_cycles(input int n, input logic [6:0] ones_pat, input logic lz_exp,
                              input logic [6:0] tens_pat);
        logic [6:0] s;
        logic [1:0] a;
        logic       d;
        logic       f;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 16;
            s = 7'h7F;
            a = 2'b11;
            d = (ph >= 8);
            f = (ph == 0);
            if (ph >= 2 && ph < 8) begin
                s = ~ones_pat;
                a = 2'b10;
            end else if (ph >= 10 && !lz_exp) begin
                s = ~tens_pat;
                a = 2'b01;
            end
            chk("an", {6'd0, an_a}, {6'd0, a});
            chk("seg", {1'b0, seg_a}, {1'b0, s});
            chk("dsel", {7'd0, ds_a}, {7'd0, d});
            chk("ftick", {7'd0, ft_a}, {7'd0, f});
            chk("an_hi", {6'd0, an_b}, {6'd0, ~a});
            chk("seg_hi", {1'b0, seg_b}, {1'b0, ~s});
            chk("dsel_hi", {7'd0, ds_b}, {7'd0, d});
            chk("ftick_hi", {7'd0, ft_b}, {7'd0, f});
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        onesseg  = 7'h06;
        tensseg  = 7'h5B;
        ten_bcd  = 4'd1;
        blank_lz = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_off("reset");
        chk("reset_dsel_hi", {7'd0, ds_b}, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        ph  = 0;
        run_cycles(32, 7'h06, 1'b0, 7'h5B);

        // Leading-zero blanking of the tens digit
        ten_bcd  = 4'd0;
        blank_lz = 1'b1;
        run_cycles(16, 7'h06, 1'b1, 7'h5B);
        ten_bcd  = 4'd1;
        blank_lz = 1'b0;

        // Ones input changes mid on-phase; held pattern must persist to next frame
        run_cycles(4, 7'h06, 1'b0, 7'h5B);
        onesseg = 7'h3F;
        run_cycles(12, 7'h06, 1'b0, 7'h5B);
        run_cycles(16, 7'h3F, 1'b0, 7'h5B);

        // Enable drop in TENS_ON cycle 3 (phase 12)
        run_cycles(12, 7'h3F, 1'b0, 7'h5B);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_off("en_low");
        end
        en = 1'b1;
        ph = 0;
        run_cycles(16, 7'h3F, 1'b0, 7'h5B);

        // Asynchronous reset between edges in ONES_ON
        run_cycles(4, 7'h3F, 1'b0, 7'h5B);
        chk("pre_rst_an", {6'd0, an_a}, 8'h02);
        #3;
        rst = 1'b1;
        #1;
        chk_off("async_rst");
        @(posedge clk);
        #1;
        chk_off("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        ph  = 0;
        run_cycles(32, 7'h3F, 1'b0, 7'h5B);

        chk("an_never_both_lo", bad_an_a[7:0], 8'h00);
        chk("an_never_both_hi", bad_an_b[7:0], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
